// File: rtl/srl_delay_ctrl.sv
// Tap-address controller for a bank of variable-depth SRL delay lines.
// Applies delay requests as a jump or a +/-1 ramp and reports tap validity from a fill counter.
module srl_delay_ctrl #(
    parameter int ADR_WIDTH     = 8,
    parameter int SRL_DEPTH     = 256,
    parameter int INIT_ADR      = 0,
    parameter int STEP_MODE     = 0,
    parameter int STEP_INTERVAL = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 delay_wr,
    input  logic [ADR_WIDTH-1:0] delay_in,
    input  logic                 flush,
    output logic [ADR_WIDTH-1:0] srl_adr,
    output logic                 q_valid,
    output logic                 busy,
    output logic                 clamp_err,
    output logic [ADR_WIDTH:0]   fill_cnt,
    output logic                 state_dbg
);

    localparam int MAX_TAP  = SRL_DEPTH - 1;
    localparam int INIT_TAP = (INIT_ADR > MAX_TAP) ? MAX_TAP : INIT_ADR;
    localparam int CNT_W    = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;

    localparam logic [ADR_WIDTH-1:0] MAX_ADR   = ADR_WIDTH'(MAX_TAP);
    localparam logic [ADR_WIDTH:0]   MAX_ADR_W = (ADR_WIDTH+1)'(MAX_TAP);
    localparam logic [ADR_WIDTH-1:0] INIT_VAL  = ADR_WIDTH'(INIT_TAP);
    localparam logic [ADR_WIDTH-1:0] ONE_ADR   = ADR_WIDTH'(1);
    localparam logic [ADR_WIDTH:0]   FILL_MAX  = (ADR_WIDTH+1)'(SRL_DEPTH);
    localparam logic [ADR_WIDTH:0]   FILL_ONE  = (ADR_WIDTH+1)'(1);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(STEP_INTERVAL - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t               state;
    logic [ADR_WIDTH-1:0] target;
    logic [CNT_W-1:0]     step_cnt;

    logic                 over_range;
    logic [ADR_WIDTH-1:0] req_tgt;
    logic [ADR_WIDTH-1:0] ramp_tgt;
    logic [ADR_WIDTH-1:0] next_step;
    logic                 jump_clear;

    // delay_wr is a one-cycle strobe with no back-pressure: the request is
    // taken on the edge where it is high, and a later strobe simply retargets.
    assign over_range = {1'b0, delay_in} > MAX_ADR_W;
    assign req_tgt    = over_range ? MAX_ADR : delay_in;
    assign ramp_tgt   = delay_wr ? req_tgt : target;
    assign next_step  = (ramp_tgt > srl_adr) ? (srl_adr + ONE_ADR) : (srl_adr - ONE_ADR);
    assign jump_clear = (STEP_MODE == 0) && delay_wr && (req_tgt != srl_adr);

    // A tap is valid once more samples have entered than its depth.
    assign q_valid   = fill_cnt > {1'b0, srl_adr};
    assign state_dbg = (state == RAMP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_cnt <= '0;
        end else if (flush || jump_clear) begin
            fill_cnt <= '0;
        end else if (fill_cnt < FILL_MAX) begin
            fill_cnt <= fill_cnt + FILL_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            srl_adr   <= INIT_VAL;
            target    <= INIT_VAL;
            state     <= IDLE;
            busy      <= 1'b0;
            step_cnt  <= '0;
            clamp_err <= 1'b0;
        end else begin
            clamp_err <= delay_wr && over_range;
            if (STEP_MODE == 0) begin
                if (delay_wr) begin
                    target  <= req_tgt;
                    srl_adr <= req_tgt;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (delay_wr) begin
                            target <= req_tgt;
                            if (req_tgt != srl_adr) begin
                                state    <= RAMP;
                                busy     <= 1'b1;
                                step_cnt <= '0;
                            end
                        end
                    end
                    RAMP: begin
                        // A retarget keeps the step phase; only arrival ends the ramp.
                        target <= ramp_tgt;
                        if (ramp_tgt == srl_adr) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            step_cnt <= '0;
                        end else if (step_cnt == CNT_LAST) begin
                            srl_adr  <= next_step;
                            step_cnt <= '0;
                        end else begin
                            step_cnt <= step_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_srl_delay_ctrl.sv
// Bench for srl_delay_ctrl: jump (8-bit), clamping jump (9-bit) and ramp instances
// checked every cycle against a behavioural model through per-instance expected queues.
module tb_srl_delay_ctrl;

    localparam int W = 24;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       wr[3];
    logic [9:0] din[3];
    logic       fl[3];

    logic [7:0] adr0, adr2;
    logic [8:0] adr1;
    logic [8:0] fill0, fill2;
    logic [9:0] fill1;
    logic qv0, qv1, qv2, bz0, bz1, bz2, ce0, ce1, ce2, st0, st1, st2;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];

    int depth[3] = '{256, 256, 256};
    int mode[3]  = '{0, 0, 1};
    int si[3]    = '{4, 4, 4};

    int m_adr[3], m_tgt[3], m_fill[3], m_ticks[3];
    bit m_ramp[3], m_clamp[3];

    srl_delay_ctrl #(.ADR_WIDTH(8), .SRL_DEPTH(256), .INIT_ADR(0), .STEP_MODE(0), .STEP_INTERVAL(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .delay_wr(wr[0]), .delay_in(din[0][7:0]), .flush(fl[0]),
        .srl_adr(adr0), .q_valid(qv0), .busy(bz0), .clamp_err(ce0), .fill_cnt(fill0), .state_dbg(st0));

    srl_delay_ctrl #(.ADR_WIDTH(9), .SRL_DEPTH(256), .INIT_ADR(0), .STEP_MODE(0), .STEP_INTERVAL(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .delay_wr(wr[1]), .delay_in(din[1][8:0]), .flush(fl[1]),
        .srl_adr(adr1), .q_valid(qv1), .busy(bz1), .clamp_err(ce1), .fill_cnt(fill1), .state_dbg(st1));

    srl_delay_ctrl #(.ADR_WIDTH(8), .SRL_DEPTH(256), .INIT_ADR(0), .STEP_MODE(1), .STEP_INTERVAL(4)) dut2 (
        .clock(clock), .reset_n(reset_n), .delay_wr(wr[2]), .delay_in(din[2][7:0]), .flush(fl[2]),
        .srl_adr(adr2), .q_valid(qv2), .busy(bz2), .clamp_err(ce2), .fill_cnt(fill2), .state_dbg(st2));

    function automatic logic [W-1:0] pack(int adr, int fill, logic qv, logic bz, logic ce, logic st);
        return {10'(adr), 10'(fill), qv, bz, ce, st};
    endfunction

    function automatic logic [W-1:0] obs(int i);
        case (i)
            0:       return pack(int'(adr0), int'(fill0), qv0, bz0, ce0, st0);
            1:       return pack(int'(adr1), int'(fill1), qv1, bz1, ce1, st1);
            default: return pack(int'(adr2), int'(fill2), qv2, bz2, ce2, st2);
        endcase
    endfunction

    task automatic check_vec(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got adr=%0d fill=%0d qv/busy/clamp/st=%b, expected adr=%0d fill=%0d qv/busy/clamp/st=%b",
                     name, $time, act[23:14], act[13:4], act[3:0], exp[23:14], exp[13:4], exp[3:0]);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural reference: tap address, fill count and ramp progress in plain integers.
    task automatic model_reset(int i);
        m_adr[i] = 0; m_tgt[i] = 0; m_fill[i] = 0; m_ticks[i] = 0;
        m_ramp[i] = 0; m_clamp[i] = 0;
    endtask

    task automatic model_step(int i);
        int maxt = depth[i] - 1;
        int d    = int'(din[i]);
        int req  = (d > maxt) ? maxt : d;
        bit clr  = fl[i];
        m_clamp[i] = wr[i] && (d > maxt);
        if (mode[i] == 0) begin
            if (wr[i] && req != m_adr[i]) begin
                m_adr[i] = req;
                clr = 1;
            end
        end else if (!m_ramp[i]) begin
            if (wr[i] && req != m_adr[i]) begin
                m_ramp[i] = 1; m_tgt[i] = req; m_ticks[i] = 0;
            end
        end else begin
            if (wr[i]) m_tgt[i] = req;
            if (m_tgt[i] == m_adr[i]) begin
                m_ramp[i] = 0; m_ticks[i] = 0;
            end else if (m_ticks[i] == si[i] - 1) begin
                m_adr[i] += (m_tgt[i] > m_adr[i]) ? 1 : -1;
                m_ticks[i] = 0;
            end else begin
                m_ticks[i]++;
            end
        end
        m_fill[i] = clr ? 0 : ((m_fill[i] < depth[i]) ? m_fill[i] + 1 : m_fill[i]);
    endtask

    function automatic logic [W-1:0] model_out(int i);
        return pack(m_adr[i], m_fill[i], m_fill[i] > m_adr[i], m_ramp[i], m_clamp[i], m_ramp[i]);
    endfunction

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) model_reset(i);
            else model_step(i);
        end
        exp_q0.push_back(model_out(0));
        exp_q1.push_back(model_out(1));
        exp_q2.push_back(model_out(2));
    end

    always @(negedge clock) begin
        if (exp_q0.size() > 0) check_vec("inst0_jump", obs(0), exp_q0.pop_front());
        if (exp_q1.size() > 0) check_vec("inst1_clamp", obs(1), exp_q1.pop_front());
        if (exp_q2.size() > 0) check_vec("inst2_ramp", obs(2), exp_q2.pop_front());
    end

    task automatic clk1();
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            wr[i] = 1'b0;
            fl[i] = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) clk1();
    endtask

    task automatic write(int i, int v);
        wr[i]  = 1'b1;
        din[i] = 10'(v);
    endtask

    task automatic count_low0(int window, output int lowc);
        lowc = 0;
        for (int k = 0; k < window; k++) begin
            if (!qv0) lowc++;
            clk1();
        end
    endtask

    task automatic wait_adr2(int v, int budget);
        int k = 0;
        while (int'(adr2) != v && k < budget) begin
            clk1();
            k++;
        end
        check_val("wait_adr2", int'(adr2), v);
    endtask

    task automatic wait_idle2(int budget);
        int k = 0;
        while (bz2 && k < budget) begin
            clk1();
            k++;
        end
        check_val("wait_idle2", int'(bz2), 0);
    endtask

    initial begin
        int lowc, t1, t2, t3, tb;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr[i] = 1'b0; fl[i] = 1'b0; din[i] = '0;
        end
        idle(3);
        reset_n = 1'b1;

        // Fill count climbs from reset and saturates.
        idle(300);
        check_val("fill_saturate", int'(fill0), 256);

        write(0, 10); clk1();
        check_val("jump_adr", int'(adr0), 10);
        count_low0(15, lowc);
        check_val("jump_blank", lowc, 11);
        write(0, 10); clk1();
        count_low0(15, lowc);
        check_val("same_tap_no_blank", lowc, 0);

        write(1, 300); clk1();
        check_val("clamp_pulse", int'(ce1), 1);
        check_val("clamp_adr", int'(adr1), 255);
        clk1();
        check_val("clamp_one_cycle", int'(ce1), 0);
        write(1, 255); clk1();
        check_val("no_clamp_at_max", int'(ce1), 0);

        write(0, 20); fl[0] = 1'b1; clk1();
        check_val("flush_wr_fill", int'(fill0), 0);
        count_low0(25, lowc);
        check_val("flush_wr_blank", lowc, 21);
        write(0, 5); clk1();
        idle(10);
        fl[0] = 1'b1; clk1();
        count_low0(10, lowc);
        check_val("lone_flush_blank", lowc, 6);

        // Ramp 0 -> 3 step timing.
        write(2, 3); clk1();
        t1 = -1; t2 = -1; t3 = -1; tb = -1;
        for (int k = 1; k <= 20; k++) begin
            if (adr2 == 8'd1 && t1 < 0) t1 = k;
            if (adr2 == 8'd2 && t2 < 0) t2 = k;
            if (adr2 == 8'd3 && t3 < 0) t3 = k;
            if (!bz2 && tb < 0) tb = k;
            clk1();
        end
        check_val("ramp_step1", t1, 5);
        check_val("ramp_step2", t2, 9);
        check_val("ramp_step3", t3, 13);
        check_val("ramp_busy_fall", tb, 14);

        write(2, 0); clk1();
        wait_idle2(100);
        write(2, 3); clk1();
        wait_adr2(2, 40);
        write(2, 1); clk1();
        wait_idle2(40);
        check_val("retarget_adr", int'(adr2), 1);

        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 11) == 0) write(0, $urandom_range(0, 255));
            if ($urandom_range(0, 11) == 0) write(1, $urandom_range(0, 511));
            if ($urandom_range(0, 11) == 0) write(2, $urandom_range(0, 40));
            for (int i = 0; i < 3; i++) if ($urandom_range(0, 39) == 0) fl[i] = 1'b1;
            clk1();
        end

        // Reset in the middle of a ramp returns everything immediately.
        write(2, 0); clk1();
        wait_idle2(300);
        write(2, 50); clk1();
        wait_adr2(7, 60);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check_vec("async_reset", obs(i), pack(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        idle(2);
        reset_n = 1'b1;
        idle(60);
        check_val("no_ramp_resume_adr", int'(adr2), 0);
        check_val("no_ramp_resume_busy", int'(bz2), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
